// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says datapath stages.
package simon_pkg;
  localparam int SEQ_W   = 32;
  localparam int ROUND_W = 4;
  localparam int CODE_W  = 2;
  localparam int BTN_W   = 4;
  localparam int STEP_W  = 5;

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, DONE} play_st_e;

  // Button colour encodings, one-hot per colour
  localparam logic [BTN_W-1:0] BTN_C0 = 4'b0001;
  localparam logic [BTN_W-1:0] BTN_C1 = 4'b0010;
  localparam logic [BTN_W-1:0] BTN_C2 = 4'b0100;
  localparam logic [BTN_W-1:0] BTN_C3 = 4'b1000;

  function automatic logic [CODE_W-1:0] btn2code(input logic [BTN_W-1:0] b);
    case (b)
      BTN_C1:  return 2'd1;
      BTN_C2:  return 2'd2;
      BTN_C3:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic is_onehot(input logic [BTN_W-1:0] b);
    return (b != '0) && ((b & (b - 1'b1)) == '0);
  endfunction
endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a run-length stability filter.
// btn_db takes the synced value once it has been seen unchanged for
// DEBOUNCE_CYCLES consecutive cycles.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int W               = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw,
  output logic [W-1:0] btn_db
);
  localparam int RUN_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0][W-1:0] sync_pipe;
  logic [W-1:0]      sync_v, last_q;
  logic [RUN_W-1:0]  run_q, run_nx;

  assign sync_v = sync_pipe[1];

  // Length of the current run of identical synced samples, saturating
  always_comb begin
    run_nx = RUN_W'(1);
    if (sync_v == last_q)
      run_nx = (run_q == RUN_W'(DEBOUNCE_CYCLES)) ? run_q : run_q + 1'b1;
  end

  // Synchroniser, run tracker and debounced output register
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_pipe <= '0;
      last_q    <= '0;
      run_q     <= '0;
      btn_db    <= '0;
    end else begin
      sync_pipe <= {sync_pipe[0], raw};
      last_q    <= sync_v;
      run_q     <= run_nx;
      if (run_nx == RUN_W'(DEBOUNCE_CYCLES) && sync_v != btn_db)
        btn_db <= sync_v;
    end
  end
endmodule

// File: rtl/play_state.sv
// Player-input capture for Simon Says: debounces buttons, packs accepted
// presses 2 bits per step into seq_play, and hands off to check_state.
// Optional inactivity timeout built when PLAY_TIMEOUT_EN is defined.
module play_state
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic               clk,
  input  logic               rst_play,
  input  logic               en_play,
  input  logic [BTN_W-1:0]   buttons,
  input  logic [ROUND_W-1:0] round_ctr_in,
  output logic [SEQ_W-1:0]   seq_play,
  output logic [STEP_W-1:0]  step_ctr,
  output logic               press_valid,
  output logic [CODE_W-1:0]  press_code,
  output logic               complete_play,
  output logic               en_check_out,
  output logic               timed_out
);
  play_st_e          state_q, state_nx;
  logic [BTN_W-1:0]  btn_db, db_prev_q;
  logic [STEP_W-1:0] target_q;
  logic              accept, release_ok, last_step, timeout;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .W(BTN_W)) u_db (
    .clk    (clk),
    .rst    (rst_play),
    .raw    (buttons),
    .btn_db (btn_db)
  );

  // Only a clean 0000 -> one-hot transition counts as a press
  assign accept     = en_play && state_q == WAIT_PRESS && db_prev_q == '0 && is_onehot(btn_db);
  assign release_ok = en_play && state_q == WAIT_RELEASE && btn_db == '0;
  assign last_step  = step_ctr == target_q;

`ifdef PLAY_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr_q;

  assign timeout = en_play && (state_q == WAIT_PRESS || state_q == WAIT_RELEASE) &&
                   !accept && !release_ok && tmr_q == TMR_W'(TIMEOUT_CYCLES - 1);

  // Inactivity timer: restarts on every press and release, latches timed_out
  always_ff @(posedge clk) begin
    if (rst_play) begin
      tmr_q     <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state_q == IDLE || accept || release_ok)
        tmr_q <= '0;
      else if (en_play && (state_q == WAIT_PRESS || state_q == WAIT_RELEASE))
        tmr_q <= tmr_q + 1'b1;
      if (timeout)
        timed_out <= 1'b1;
    end
  end
`else
  assign timeout   = 1'b0;
  // Parameter only matters in the timeout build; referenced to stay lint-quiet
  assign timed_out = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst_play) state_q <= IDLE;
    else          state_q <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:         if (en_play) state_nx = WAIT_PRESS;
      WAIT_PRESS:   if (accept) state_nx = WAIT_RELEASE;
                    else if (timeout) state_nx = DONE;
      WAIT_RELEASE: if (release_ok) state_nx = last_step ? DONE : WAIT_PRESS;
                    else if (timeout) state_nx = DONE;
      default:      state_nx = DONE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    complete_play = (state_q == DONE);
  end

  // Capture datapath: target latch, sequence packing and handoff pulses
  always_ff @(posedge clk) begin
    if (rst_play) begin
      db_prev_q    <= '0;
      target_q     <= '0;
      seq_play     <= '0;
      step_ctr     <= '0;
      press_code   <= '0;
      press_valid  <= 1'b0;
      en_check_out <= 1'b0;
    end else begin
      db_prev_q    <= btn_db;
      press_valid  <= accept;
      en_check_out <= release_ok && last_step;
      if (state_q == IDLE) begin
        seq_play   <= '0;
        step_ctr   <= '0;
        press_code <= '0;
        if (en_play) target_q <= {1'b0, round_ctr_in} + 5'd1;
      end
      if (accept) begin
        seq_play[{step_ctr[3:0], 1'b0} +: CODE_W] <= btn2code(btn_db);
        step_ctr   <= step_ctr + 5'd1;
        press_code <= btn2code(btn_db);
      end
    end
  end
endmodule

// File: doc/play_state.md
# play_state

Player-input capture stage of the Simon Says game, directly upstream of `check_state`. It synchronises and debounces the four push-buttons and encodes each accepted press as a 2-bit code. Codes are packed into a 32-bit sequence in the same layout as `seq_mem`. Once `round_ctr_in + 1` presses are complete, it presents the finished sequence and pulses the enable that starts `check_state`.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required before the debounced button value updates (≥1).
- `TIMEOUT_CYCLES`, 1000: inactivity limit per press. Used only when `PLAY_TIMEOUT_EN` is defined.
- `clk` in 1: single system clock.
- `rst_play` in 1: reset, synchronous, active-high.
- `en_play` in 1: level enable from the top FSM. Low freezes capture.
- `buttons` in 4: raw, asynchronous push-buttons, one-hot per colour.
- `round_ctr_in` in 4: current round. Press target is `round_ctr_in + 1`.
- `seq_play` out 32: captured sequence, connected to `check_state.seq_in_check`.
- `step_ctr` out 5: presses accepted so far, 0..16.
- `press_valid` out 1: 1-cycle pulse per accepted press.
- `press_code` out 2: code of the last accepted press, used for LED feedback.
- `complete_play` out 1: level, high while in DONE.
- `en_check_out` out 1: 1-cycle pulse on DONE entry, drives `check_state.en_check`.
- `timed_out` out 1: level, high on timeout. Tied 0 without the macro.

## Operation
- Input path:
  - 2-flop synchroniser on `buttons`.
  - The debouncer updates `btn_db` only after the synced value has been stable for `DEBOUNCE_CYCLES` consecutive cycles.
- Code mapping: `4'b0001`→0, `0010`→1, `0100`→2, `1000`→3.
- Press acceptance: `btn_db` goes from `0000` to a one-hot value while in WAIT_PRESS.
  - A multi-hot value is ignored.
  - A direct change between two non-zero values, without passing through `0000`, is ignored.
- Packing: step k occupies `seq_play[2k+1:2k]`, with step 0 at bits [1:0]. Unfilled bits stay 0.
- FSM states:
  - IDLE: all outputs 0. When `en_play` is 1, latch target = `round_ctr_in + 1` (5-bit, 1..16), clear `seq_play` and `step_ctr`, go to WAIT_PRESS.
  - WAIT_PRESS: on an accepted press, write the code at slot `step_ctr`, increment `step_ctr`, go to WAIT_RELEASE.
  - WAIT_RELEASE: wait for `btn_db == 0000`. Then go to DONE if `step_ctr == target`, otherwise back to WAIT_PRESS.
  - DONE: hold `seq_play`. `complete_play` is 1. `en_check_out` pulses on the entry cycle only. Leave only via `rst_play`.
- `en_play` low in WAIT_PRESS or WAIT_RELEASE:
  - State, counters and timer are frozen.
  - Button edges are not accepted.
  - Debouncer/synchroniser keep running.
- `round_ctr_in` changes after IDLE are ignored, because the target is latched.
- Round 15 gives target 16, which fills all 32 bits. No overflow.

## Timing
- All outputs reset to 0 the cycle after `rst_play` is sampled high. `rst_play` overrides everything, including mid-press and DONE.
- Raw edge to `btn_db` change: 2 sync cycles + `DEBOUNCE_CYCLES`.
- Accepted press (`btn_db` edge cycle N):
  - `seq_play`, `step_ctr`, `press_code` update and `press_valid` = 1 at N+1.
- Final release (`btn_db` = 0 at cycle M):
  - DONE entered, `complete_play` = 1 and `en_check_out` = 1 at M+1.
  - `en_check_out` = 0 at M+2.
- Glitches shorter than `DEBOUNCE_CYCLES` never reach FSM.

## Configuration
- `PLAY_TIMEOUT_EN` defined:
  - A counter runs in WAIT_PRESS and WAIT_RELEASE. It clears on every accepted press and every release.
  - Reaching `TIMEOUT_CYCLES` → go to DONE with `timed_out` = 1 and `complete_play` = 1. `en_check_out` is NOT pulsed, and the top FSM routes to fail/idle.
- `PLAY_TIMEOUT_EN` not defined: no counter is built, `timed_out` is constant 0, and the FSM waits indefinitely.

## Structure
- Shared package `simon_pkg` holds:
  - the state enum (IDLE, WAIT_PRESS, WAIT_RELEASE, DONE);
  - `SEQ_W` = 32, `ROUND_W` = 4, `CODE_W` = 2;
  - button-to-code constants.
- One sub-module, `button_debounce`: synchroniser plus stability counter, 4-bit wide, parameter `DEBOUNCE_CYCLES`.

## Test plan
- Round 0, press `4'b0100` held 10 cycles then release → `seq_play` = `32'h0000_0002`, `step_ctr` = 1, one `press_valid`, `complete_play` = 1, single `en_check_out` pulse.
- Round 2, presses 1, 3, 0 (`0010`, `1000`, `0001`) each with release → `seq_play` = `32'h0000_000D`, `step_ctr` = 3, DONE only after the third release.
- Round 1, 2-cycle glitch on `0001` then valid press `0010`, then `0110` held 10 cycles, then valid `1000` → glitch and multi-hot ignored. `seq_play` = `32'h0000_000D`.
- Round 15, sixteen presses of `1000` → `seq_play` = `32'hFFFF_FFFF`, `step_ctr` = 16, DONE.
- Round 3, `rst_play` asserted after 2 presses → next cycle all outputs 0, state IDLE. Re-enabling restarts from step 0.
- With `PLAY_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 50, round 1, one press then idle → `timed_out` = 1 and `complete_play` = 1 exactly 50 cycles after the release, with no `en_check_out` pulse.
